// File: rtl/bound_lookup_arbiter_if.sv
// Bundle between the probe requesters, the bound ROM read port and the lookup arbiter.
// The arbiter takes the slave side; requesters plus ROM sit on the master side.
interface bound_lookup_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]    req;
   logic [NUM_REQ*10-1:0] req_x;
   logic [NUM_REQ*10-1:0] req_y;
   logic [NUM_REQ-1:0]    grant;
   logic [18:0]           ram_address;
   logic                  ram_q;
   logic [NUM_REQ-1:0]    rsp_valid;
   logic [NUM_REQ-1:0]    result;
   logic                  busy;

   modport slave (
      input  req, req_x, req_y, ram_q,
      output grant, ram_address, rsp_valid, result, busy
   );

   modport master (
      output req, req_x, req_y, ram_q,
      input  grant, ram_address, rsp_valid, result, busy
   );
endinterface

// File: rtl/bound_lookup_arbiter.sv
// Round-robin sharing of one bound-ROM read port between NUM_REQ probe requesters.
// Each grant carries a tag down a fixed-latency pipeline that steers ram_q back to its owner.
module bound_lookup_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int LINE_W      = 640,
   parameter int NUM_ROWS    = 480,
   parameter int X_OFF       = 16,
   parameter int Y_OFF       = 6,
   parameter int RAM_LATENCY = 2
) (
   input logic                   Clk,
   input logic                   Reset,
   bound_lookup_arbiter_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_REQ);

   typedef logic [IDX_W-1:0] idx_t;
   typedef struct packed {
      logic valid;
      idx_t idx;
      logic oob;
   } tag_t;

   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
   logic [NUM_REQ-1:0] result_q, result_d;
   logic [NUM_REQ-1:0] inflight_q, inflight_d;
   logic [18:0]        ram_address_q, ram_address_d;
   idx_t               ptr_q, ptr_d;
   tag_t               tag_q [0:RAM_LATENCY];
   tag_t               tag_d;
   tag_t               tail;

   logic [NUM_REQ-1:0] eligible;
   logic               found;
   idx_t               win_idx, cand;
   logic [9:0]         sel_x, sel_y;
   logic [10:0]        xx, yy;
   logic [18:0]        addr_in_range;
   logic               oob;

   assign eligible = bus.req & ~inflight_q;

   // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
   always_comb begin
      found   = 1'b0;
      win_idx = '0;
      cand    = '0;
      sel_x   = '0;
      sel_y   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = idx_t'((int'(ptr_q) + k) % NUM_REQ);
         if (!found && eligible[cand]) begin
            found   = 1'b1;
            win_idx = cand;
         end
      end
      for (int k = 0; k < NUM_REQ; k++) begin
         if (idx_t'(k) == win_idx) begin
            sel_x = bus.req_x[k*10 +: 10];
            sel_y = bus.req_y[k*10 +: 10];
         end
      end
   end

   // Only in-range addresses reach the ROM, and those always fit in 19 bits.
   assign xx            = 11'(sel_x) + 11'(X_OFF);
   assign yy            = 11'(sel_y) + 11'(Y_OFF);
   assign oob           = (yy >= 11'(NUM_ROWS)) || (xx >= 11'(LINE_W));
   assign addr_in_range = 19'(yy) * 19'(LINE_W) + 19'(xx);
   assign tail          = tag_q[RAM_LATENCY];

   always_comb begin
      grant_d       = '0;
      ram_address_d = ram_address_q;
      ptr_d         = ptr_q;
      tag_d         = '0;
      if (found) begin
         grant_d[win_idx] = 1'b1;
         ptr_d            = (win_idx == idx_t'(NUM_REQ - 1)) ? '0 : win_idx + idx_t'(1);
         tag_d            = '{valid: 1'b1, idx: win_idx, oob: oob};
         if (!oob) ram_address_d = addr_in_range;
      end

      rsp_valid_d = '0;
      result_d    = result_q;
      if (tail.valid) begin
         rsp_valid_d[tail.idx] = 1'b1;
         result_d[tail.idx]    = tail.oob | bus.ram_q;
      end
      inflight_d = (inflight_q & ~rsp_valid_d) | grant_d;
   end

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         grant_q       <= '0;
         rsp_valid_q   <= '0;
         result_q      <= '0;
         inflight_q    <= '0;
         ram_address_q <= '0;
         ptr_q         <= '0;
         // NOTE: the tag pipeline is reset (unlike a data array) since a stale valid bit would fire a response.
         for (int s = 0; s <= RAM_LATENCY; s++) tag_q[s] <= '0;
      end else begin
         grant_q       <= grant_d;
         rsp_valid_q   <= rsp_valid_d;
         result_q      <= result_d;
         inflight_q    <= inflight_d;
         ram_address_q <= ram_address_d;
         ptr_q         <= ptr_d;
         tag_q[0]      <= tag_d;
         for (int s = 1; s <= RAM_LATENCY; s++) tag_q[s] <= tag_q[s-1];
      end
   end

   assign bus.grant       = grant_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.result      = result_q;
   assign bus.ram_address = ram_address_q;
   assign bus.busy        = |inflight_q;
endmodule
